multi_ch_ds_dac: RTL and testbench

- Parametrised multi-channel delta-sigma audio DAC, the successor to the single-channel 1-bit modulator.
- Accepts NCH-channel PCM frames over a valid/ready stream into a double buffer.
- Each sample_stb (sample rate) promotes a frame to the active register.
- Runs NCH independent 1st- or 2nd-order modulators at the clk_en rate. Sits between the audio sample source (FIFO/DMA) and the pin-level 1-bit outputs.

---
 rtl/multi_ch_ds_dac.sv | 146 ++++++++++++++
 tb/tb_multi_ch_ds_dac.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_ds_dac.sv
// Multi-channel delta-sigma DAC: double-buffered PCM frame input, NCH 1st/2nd-order 1-bit modulators.
// Optional `define DS_DAC_SAT_EN: saturating accumulators with sticky per-channel overflow flags.
module multi_ch_ds_dac #(
   parameter int W     = 16,
   parameter int NCH   = 2,
   parameter int ORDER = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic             sample_stb,
   input  logic [NCH*W-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             mute,
   input  logic             underrun_clr,
   output logic             underrun,
   output logic [NCH-1:0]   overflow,
   output logic [NCH-1:0]   out
);

   if (ORDER != 1 && ORDER != 2) begin : g_bad_order
      $error("multi_ch_ds_dac: ORDER must be 1 or 2");
   end
   if (NCH < 1 || NCH > 8) begin : g_bad_nch
      $error("multi_ch_ds_dac: NCH must be 1..8");
   end

   logic [NCH*W-1:0] next_r;
   logic [NCH*W-1:0] active_r;
   logic             next_full;
   logic             hs;

   assign s_ready = ~next_full;
   assign hs      = s_valid & ~next_full;

   // An empty buffer on sample_stb can still be served by a frame arriving in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         next_r    <= '0;
         active_r  <= '0;
         next_full <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         if (sample_stb) begin
            if (next_full) begin
               active_r  <= mute ? '0 : next_r;
               next_full <= 1'b0;
            end else if (hs) begin
               active_r  <= mute ? '0 : s_data;
            end else if (mute) begin
               active_r  <= '0;
            end
         end else if (hs) begin
            next_r    <= s_data;
            next_full <= 1'b1;
         end
         if (sample_stb && !next_full && !hs)
            underrun <= 1'b1;
         else if (underrun_clr)
            underrun <= 1'b0;
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic [W-1:0] x;
      logic         out_q;

      assign x      = active_r[c*W +: W];
      assign out[c] = out_q;

      if (ORDER == 1) begin : g_o1
         localparam logic [W:0] HALF = (W+1)'(1) << (W-1);
         logic [W-1:0] acc;
         logic [W:0]   b;
         logic [W:0]   acc_nx;

         // Offset-binary input, so the carry out of the W-bit error accumulator is the bit stream.
         assign b      = {x[W-1], x} + HALF;
         assign acc_nx = {1'b0, acc} + b;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               acc   <= '0;
               out_q <= 1'b0;
            end else if (clk_en) begin
               acc   <= acc_nx[W-1:0];
               out_q <= acc_nx[W];
            end
         end
         assign overflow[c] = 1'b0;
      end else begin : g_o2
         localparam int A1 = W + 3;
         localparam int A2 = W + 5;
         localparam logic signed [A1-1:0] ONE1 = A1'(1) << W;
         localparam logic signed [A2-1:0] ONE2 = A2'(1) << W;
         logic signed [A1-1:0] acc1, d1, raw1, s1, fb1;
         logic signed [A2-1:0] acc2, d2, raw2, s2, fb2;

         assign fb1  = out_q ? -ONE1 : ONE1;
         assign fb2  = out_q ? -ONE2 : ONE2;
         assign d1   = $signed({{3{x[W-1]}}, x}) + fb1;
         assign raw1 = acc1 + d1;
         assign d2   = $signed({{2{s1[A1-1]}}, s1}) + fb2;
         assign raw2 = acc2 + d2;

`ifdef DS_DAC_SAT_EN
         localparam logic signed [A1-1:0] MAX1 = {1'b0, {(A1-1){1'b1}}};
         localparam logic signed [A1-1:0] MIN1 = {1'b1, {(A1-1){1'b0}}};
         localparam logic signed [A2-1:0] MAX2 = {1'b0, {(A2-1){1'b1}}};
         localparam logic signed [A2-1:0] MIN2 = {1'b1, {(A2-1){1'b0}}};
         logic v1, v2, ovf_q;

         assign v1 = (acc1[A1-1] == d1[A1-1]) && (raw1[A1-1] != acc1[A1-1]);
         assign v2 = (acc2[A2-1] == d2[A2-1]) && (raw2[A2-1] != acc2[A2-1]);
         assign s1 = v1 ? (acc1[A1-1] ? MIN1 : MAX1) : raw1;
         assign s2 = v2 ? (acc2[A2-1] ? MIN2 : MAX2) : raw2;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               ovf_q <= 1'b0;
            else if (clk_en && (v1 || v2))
               ovf_q <= 1'b1;
         end
         assign overflow[c] = ovf_q;
`else
         assign s1 = raw1;
         assign s2 = raw2;
         assign overflow[c] = 1'b0;
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               acc1  <= '0;
               acc2  <= '0;
               out_q <= 1'b0;
            end else if (clk_en) begin
               acc1  <= s1;
               acc2  <= s2;
               out_q <= ~s2[A2-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_ch_ds_dac.sv
// Bench for multi_ch_ds_dac: ORDER=1 and ORDER=2 instances share stimulus and are compared
// every cycle against a frame-queue / real-arithmetic reference, plus ones-density checks.
module tb_multi_ch_ds_dac;
   localparam int W   = 16;
   localparam int NCH = 2;

   logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, sample_stb = 1'b0;
   logic s_valid = 1'b0, mute = 1'b0, underrun_clr = 1'b0;
   logic [NCH*W-1:0] s_data = '0;
   logic s_ready1, s_ready2, underrun1, underrun2;
   logic [NCH-1:0] ovf1, ovf2, out1, out2;

   always #5 clk = ~clk;

   multi_ch_ds_dac #(.W(W), .NCH(NCH), .ORDER(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sample_stb(sample_stb),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1), .mute(mute),
      .underrun_clr(underrun_clr), .underrun(underrun1), .overflow(ovf1), .out(out1));

   multi_ch_ds_dac #(.W(W), .NCH(NCH), .ORDER(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sample_stb(sample_stb),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2), .mute(mute),
      .underrun_clr(underrun_clr), .underrun(underrun2), .overflow(ovf2), .out(out2));

   int     n_cmp = 0, n_bad = 0;
   int     m_act[NCH], m_nxt[NCH];
   bit     m_full, m_und;
   longint m_err[NCH];
   bit     m_o1[NCH], m_o2[NCH];
   real    m_a1[NCH], m_a2[NCH];
   int     cnt1[NCH], cnt2[NCH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      n_cmp++;
      assert (obs >= lo && obs <= hi) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic model_reset();
      m_full = 0;
      m_und  = 0;
      for (int c = 0; c < NCH; c++) begin
         m_act[c] = 0; m_nxt[c] = 0; m_err[c] = 0;
         m_o1[c] = 0; m_o2[c] = 0; m_a1[c] = 0.0; m_a2[c] = 0.0;
      end
   endtask

   task automatic clr_cnt();
      for (int c = 0; c < NCH; c++) begin
         cnt1[c] = 0;
         cnt2[c] = 0;
      end
   endtask

   task automatic set_frame(input int v0, input int v1);
      s_data[0 +: W] = W'(v0);
      s_data[W +: W] = W'(v1);
   endtask

   // One clock: advance the reference from the pre-edge inputs, then compare after the edge.
   task automatic tick();
      bit  hs, und_set;
      int  d[NCH];
      real x, fb;
      logic [NCH-1:0] e1, e2;
      hs = s_valid && !m_full;
      for (int c = 0; c < NCH; c++) d[c] = int'($signed(s_data[c*W +: W]));
      if (clk_en) begin
         for (int c = 0; c < NCH; c++) begin
            m_err[c] = m_err[c] + m_act[c] + 2**(W-1);
            m_o1[c]  = (m_err[c] >= 2**W);
            if (m_o1[c]) m_err[c] = m_err[c] - 2**W;
            x  = real'(m_act[c]) / (2.0 ** W);
            fb = m_o2[c] ? -1.0 : 1.0;
            m_a1[c] = m_a1[c] + x + fb;
            m_a2[c] = m_a2[c] + m_a1[c] + fb;
            m_o2[c] = (m_a2[c] >= 0.0);
         end
      end
      und_set = sample_stb && !m_full && !hs;
      if (sample_stb) begin
         for (int c = 0; c < NCH; c++) begin
            if (m_full)   m_act[c] = mute ? 0 : m_nxt[c];
            else if (hs)  m_act[c] = mute ? 0 : d[c];
            else if (mute) m_act[c] = 0;
         end
         m_full = 0;
      end else if (hs) begin
         for (int c = 0; c < NCH; c++) m_nxt[c] = d[c];
         m_full = 1;
      end
      if (und_set) m_und = 1;
      else if (underrun_clr) m_und = 0;
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
         e1[c] = m_o1[c];
         e2[c] = m_o2[c];
         if (clk_en) begin
            cnt1[c] += int'(out1[c]);
            cnt2[c] += int'(out2[c]);
         end
      end
      chk("out_o1", out1, e1);
      chk("out_o2", out2, e2);
      chk("s_ready_o1", s_ready1, !m_full);
      chk("s_ready_o2", s_ready2, !m_full);
      chk("underrun_o1", underrun1, m_und);
      chk("underrun_o2", underrun2, m_und);
      chk("overflow_o1", ovf1, '0);
      chk("overflow_o2", ovf2, '0);
   endtask

   task automatic run_en(input int n);
      for (int i = 0; i < n; i++) begin
         clk_en = 1'b1; tick();
         clk_en = 1'b0; tick();
      end
   endtask

   task automatic load(input int v0, input int v1);
      s_valid = 1'b1; set_frame(v0, v1); tick();
      s_valid = 1'b0; sample_stb = 1'b1; tick();
      sample_stb = 1'b0;
   endtask

   task automatic do_reset();
      clk_en = 0; sample_stb = 0; s_valid = 0; mute = 0; underrun_clr = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_o1", out1, '0);
      chk("rst_out_o2", out2, '0);
      chk("rst_s_ready", {s_ready1, s_ready2}, 2'b11);
      chk("rst_underrun", {underrun1, underrun2}, 2'b00);
      chk("rst_overflow", {ovf1, ovf2}, '0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      clr_cnt();
      @(negedge clk);
      chk("por_out", {out1, out2}, '0);
      chk("por_s_ready", {s_ready1, s_ready2}, 2'b11);
      chk("por_underrun", {underrun1, underrun2}, 2'b00);
      rst_n = 1'b1;

      // Run with real data, then reset mid-stream and measure idle density.
      load(12345, -20000);
      run_en(37);
      do_reset();
      clr_cnt();
      run_en(100);
      for (int c = 0; c < NCH; c++) begin
         chk_rng($sformatf("idle_density_o1_ch%0d", c), cnt1[c], 49, 51);
         chk_rng($sformatf("idle_density_o2_ch%0d", c), cnt2[c], 49, 51);
      end

      // Backpressure: F1 fills the buffer, F2 stalls until a sample_stb drains it.
      s_valid = 1'b1; set_frame(1000, -1000); tick();
      chk("bp_ready_low", s_ready1, 1'b0);
      set_frame(-7000, 9000); tick(); tick();
      sample_stb = 1'b1; tick(); sample_stb = 1'b0;
      chk("bp_ready_after_stb", s_ready2, 1'b1);
      tick();
      chk("bp_f2_accepted", s_ready1, 1'b0);
      s_valid = 1'b0;
      run_en(20);
      sample_stb = 1'b1; tick(); sample_stb = 1'b0;
      run_en(20);

      // Density: first 4096 clk_en for ORDER=1, full 8192 for ORDER=2.
      load(16384, -16384);
      clr_cnt();
      run_en(4096);
      chk_rng("dens_o1_ch0_pos", cnt1[0], 3071, 3073);
      chk_rng("dens_o1_ch1_neg", cnt1[1], 1023, 1025);
      run_en(4096);
      chk_rng("dens_o2_ch0_pos", cnt2[0], 5116, 5124);
      chk_rng("dens_o2_ch1_neg", cnt2[1], 3068, 3076);

      load(-32768, 32767);
      clr_cnt();
      run_en(8192);
      chk_rng("dens_o2_ch0_min", cnt2[0], 2044, 2052);
      chk_rng("dens_o2_ch1_max", cnt2[1], 6140, 6148);
      chk_rng("dens_o1_ch0_min", cnt1[0], 0, 0);
      chk_rng("dens_o1_ch1_max", cnt1[1], 8191, 8192);
      chk("ovf_after_extremes", ovf2, '0);

      // Underrun: empty strobe sets; clear loses to a coincident set; coincident handshake avoids it.
      sample_stb = 1'b1; tick(); sample_stb = 1'b0;
      chk("und_set", underrun1, 1'b1);
      run_en(5);
      sample_stb = 1'b1; underrun_clr = 1'b1; tick();
      sample_stb = 1'b0; underrun_clr = 1'b0;
      chk("und_set_wins", underrun2, 1'b1);
      underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
      chk("und_cleared", underrun1, 1'b0);
      s_valid = 1'b1; set_frame(-3000, 25000); sample_stb = 1'b1; tick();
      s_valid = 1'b0; sample_stb = 1'b0;
      chk("und_coincident_hs", underrun2, 1'b0);
      chk("coincident_ready", s_ready1, 1'b1);
      run_en(50);

      // Mute: buffered full-scale frame is consumed but promoted as zero.
      s_valid = 1'b1; set_frame(32767, 32767); tick(); s_valid = 1'b0;
      mute = 1'b1; sample_stb = 1'b1; tick(); mute = 1'b0; sample_stb = 1'b0;
      chk("mute_consumed", s_ready2, 1'b1);
      clr_cnt();
      run_en(200);
      for (int c = 0; c < NCH; c++) begin
         chk_rng($sformatf("mute_density_o1_ch%0d", c), cnt1[c], 99, 101);
         chk_rng($sformatf("mute_density_o2_ch%0d", c), cnt2[c], 96, 104);
      end

      // Randomised traffic, with one reset in the middle.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         s_valid      = 1'($urandom_range(0, 1));
         for (int c = 0; c < NCH; c++) s_data[c*W +: W] = W'($urandom);
         sample_stb   = ($urandom_range(0, 7) == 0);
         clk_en       = 1'($urandom_range(0, 1));
         mute         = ($urandom_range(0, 15) == 0);
         underrun_clr = ($urandom_range(0, 7) == 0);
         tick();
      end
      clk_en = 0; sample_stb = 0; s_valid = 0; mute = 0; underrun_clr = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
